// File: rtl/if_id_buf_pkg.sv
// Shared constants and types for the IF/ID instruction buffer.
//   RST_ENABLE / STOP / NO_STOP : control-level encodings used by the pipeline
//   ZERO_WORD                   : nop / cleared instruction and address value
//   INST_ADDR_BUS / INST_BUS    : default address and instruction widths
//   STALL_ID                    : stall-vector bit that means "decode stalled"
//   id_sel_e                    : source select for the decode-stage register
package if_id_buf_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        STOP          = 1'b1;
  localparam logic        NO_STOP       = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam int          INST_ADDR_BUS = 32;
  localparam int          INST_BUS      = 32;
  localparam int          STALL_ID      = 2;

  typedef enum logic [1:0] {
    SEL_ZERO,   // reset, flush or bubble
    SEL_HOLD,   // decode stalled
    SEL_HEAD,   // oldest queued instruction
    SEL_FETCH   // empty queue, fetch bypasses straight into decode
  } id_sel_e;

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch-side valid/ready handshake.
//   valid : fetch presents an instruction
//   pc    : fetched instruction address
//   inst  : fetched instruction word
//   ready : buffer can accept this cycle
// master = fetch stage, slave = buffer.
interface if_id_buf_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst;

  modport master (output valid, output pc, output inst, input ready);
  modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/if_id_buf_inst_queue.sv
// inst_queue: circular buffer of DEPTH entries, WIDTH bits each.
//   clear : drop every entry and return pointers to 0 in one edge
//   push  : write din at the tail (caller guarantees !full)
//   pop   : discard the head (caller guarantees count != 0)
//   head  : oldest entry, full : no free slot, count : entries held
// Storage has no reset; it is written only on push.
module inst_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH need not be a power of two, so wrap by compare rather than overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
endmodule

// File: rtl/if_id_buf.sv
// if_id_buf: IF/ID pipeline boundary with a small instruction queue so fetch
// can run ahead while decode is stalled.
//   clk, rst : clock, synchronous active-high reset
//   stall    : pipeline stall vector, only the decode bit is used
//   flush    : exception flush, empties queue and decode register
//   fetch    : valid/pc/inst in, ready out (slave side of the handshake)
//   id_*     : registered decode-stage pc/instruction/valid
//   q_count  : entries queued behind the decode register
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int INST_W = INST_BUS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5:0]                  stall,
  input  logic                        flush,
  if_id_buf_if.slave                  fetch,
  output logic [ADDR_W-1:0]           id_pc,
  output logic [INST_W-1:0]           id_inst,
  output logic                        id_valid,
  output logic [$clog2(DEPTH+1)-1:0]  q_count
);
  localparam int WIDTH = ADDR_W + INST_W;

  logic              q_full, q_push, q_pop, push;
  logic [WIDTH-1:0]  q_head;
  id_sel_e           sel;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              unused_stall;

  assign unused_stall = ^{stall[5:3], stall[1:0]};

  // Ready depends only on state so fetch never sees a combinational loop
  // through stall; a pop in the same cycle does not free the slot early.
  assign fetch.ready = (rst != RST_ENABLE) && !q_full;
  assign push        = fetch.valid && fetch.ready;

  always_comb begin
    sel    = SEL_HOLD;
    q_push = 1'b0;
    q_pop  = 1'b0;
    if (rst == RST_ENABLE || flush) begin
      sel = SEL_ZERO;
    end else if (stall[STALL_ID] == STOP) begin
      q_push = push;
    end else if (q_count != '0) begin
      sel    = SEL_HEAD;
      q_pop  = 1'b1;
      q_push = push;
    end else if (fetch.valid) begin
      // Empty queue implies ready, so this instruction is consumed here.
      sel = SEL_FETCH;
    end else begin
      sel = SEL_ZERO;
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    case (sel)
      SEL_ZERO: begin
        id_pc_d    = ADDR_W'(ZERO_WORD);
        id_inst_d  = INST_W'(ZERO_WORD);
        id_valid_d = 1'b0;
      end
      SEL_HEAD: begin
        id_pc_d    = q_head[INST_W +: ADDR_W];
        id_inst_d  = q_head[INST_W-1:0];
        id_valid_d = 1'b1;
      end
      SEL_FETCH: begin
        id_pc_d    = fetch.pc;
        id_inst_d  = fetch.inst;
        id_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  inst_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({fetch.pc, fetch.inst}),
    .head  (q_head),
    .full  (q_full),
    .count (q_count)
  );

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
endmodule

// File: tb/tb_if_id_buf.sv
module tb_if_id_buf;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [5:0] stall;
  logic       vld;

  logic [31:0] f_pc   [3];
  logic [31:0] f_inst [3];
  logic [31:0] d_id_pc   [3];
  logic [31:0] d_id_inst [3];
  logic        d_id_val  [3];
  logic        d_rdy     [3];
  logic [3:0]  d_cnt     [3];
  logic [0:0]  cnt1;
  logic [1:0]  cnt2;
  logic [2:0]  cnt5;

  int dep [3] = '{1, 2, 5};

  // reference model: per instance a plain queue plus the decode-stage values
  logic [63:0] mq    [3][$];
  logic [31:0] m_pc  [3];
  logic [31:0] m_ins [3];
  logic        m_val [3];
  logic        took  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_buf_if #(.ADDR_W(32), .INST_W(32)) f1 ();
  if_id_buf_if #(.ADDR_W(32), .INST_W(32)) f2 ();
  if_id_buf_if #(.ADDR_W(32), .INST_W(32)) f5 ();

  assign f1.valid = vld;  assign f1.pc = f_pc[0];  assign f1.inst = f_inst[0];
  assign f2.valid = vld;  assign f2.pc = f_pc[1];  assign f2.inst = f_inst[1];
  assign f5.valid = vld;  assign f5.pc = f_pc[2];  assign f5.inst = f_inst[2];
  assign d_rdy[0] = f1.ready;
  assign d_rdy[1] = f2.ready;
  assign d_rdy[2] = f5.ready;
  assign d_cnt[0] = {3'b0, cnt1};
  assign d_cnt[1] = {2'b0, cnt2};
  assign d_cnt[2] = {1'b0, cnt5};

  if_id_buf #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .fetch(f1),
    .id_pc(d_id_pc[0]), .id_inst(d_id_inst[0]), .id_valid(d_id_val[0]), .q_count(cnt1));
  if_id_buf #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .fetch(f2),
    .id_pc(d_id_pc[1]), .id_inst(d_id_inst[1]), .id_valid(d_id_val[1]), .q_count(cnt2));
  if_id_buf #(.DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .fetch(f5),
    .id_pc(d_id_pc[2]), .id_inst(d_id_inst[2]), .id_valid(d_id_val[2]), .q_count(cnt5));

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s depth=%0d t=%0t act=%0h exp=%0h", name, dep[k], $time, act, exp);
    end
  endtask

  // one clock: model absorbs the edge, DUTs are compared, fetch advances
  task automatic tick();
    logic [63:0] e;
    logic        rdy_pre;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rdy_pre = !rst && (mq[k].size() < dep[k]);
      took[k] = vld && rdy_pre;
      if (rst || flush) begin
        mq[k].delete();
        m_pc[k] = 0; m_ins[k] = 0; m_val[k] = 1'b0;
      end else if (stall[2]) begin
        if (took[k]) mq[k].push_back({f_pc[k], f_inst[k]});
      end else if (mq[k].size() > 0) begin
        e = mq[k].pop_front();
        m_pc[k] = e[63:32]; m_ins[k] = e[31:0]; m_val[k] = 1'b1;
        if (took[k]) mq[k].push_back({f_pc[k], f_inst[k]});
      end else if (vld) begin
        m_pc[k] = f_pc[k]; m_ins[k] = f_inst[k]; m_val[k] = 1'b1;
      end else begin
        m_pc[k] = 0; m_ins[k] = 0; m_val[k] = 1'b0;
      end
      check("id_pc",    k, 64'(d_id_pc[k]),   64'(m_pc[k]));
      check("id_inst",  k, 64'(d_id_inst[k]), 64'(m_ins[k]));
      check("id_valid", k, 64'(d_id_val[k]),  64'(m_val[k]));
      check("q_count",  k, 64'(d_cnt[k]),     64'(mq[k].size()));
      check("if_ready", k, 64'(d_rdy[k]),     64'(!rst && (mq[k].size() < dep[k])));
      if (took[k]) begin
        f_pc[k]   = f_pc[k] + 32'd4;
        f_inst[k] = $urandom;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'b0; vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f_pc[k] = 32'h0; f_inst[k] = $urandom | 32'h1;
      m_pc[k] = 0; m_ins[k] = 0; m_val[k] = 1'b0; took[k] = 1'b0;
    end
    tick(); tick();
    check("lit_rst_ready", 1, 64'(d_rdy[1]),    64'd0);
    check("lit_rst_pc",    1, 64'(d_id_pc[1]),  64'd0);
    check("lit_rst_valid", 1, 64'(d_id_val[1]), 64'd0);
    check("lit_rst_cnt",   1, 64'(d_cnt[1]),    64'd0);

    // steady fetch, no stall: pure bypass
    rst = 1'b0; vld = 1'b1;
    tick();
    check("lit_byp0_pc",    1, 64'(d_id_pc[1]),  64'h0);
    check("lit_byp0_valid", 1, 64'(d_id_val[1]), 64'd1);
    check("lit_ready_after_rst", 1, 64'(d_rdy[1]), 64'd1);
    tick();
    check("lit_byp4_pc",  1, 64'(d_id_pc[1]), 64'h4);
    tick();
    check("lit_byp8_pc",  1, 64'(d_id_pc[1]), 64'h8);
    check("lit_byp8_cnt", 1, 64'(d_cnt[1]),   64'd0);
    tick();

    // decode stalled three cycles: 0x10, 0x14 queue, 0x18 refused
    stall = 6'b000100;
    tick(); tick(); tick();
    check("lit_hold_pc",   1, 64'(d_id_pc[1]), 64'hC);
    check("lit_full_cnt",  1, 64'(d_cnt[1]),   64'd2);
    check("lit_full_rdy",  1, 64'(d_rdy[1]),   64'd0);

    // release: push refused on the popping edge, accepted afterwards
    stall = 6'b0;
    tick();
    check("lit_rel_pc10",  1, 64'(d_id_pc[1]), 64'h10);
    check("lit_rel_cnt",   1, 64'(d_cnt[1]),   64'd1);
    tick();
    check("lit_rel_pc14",  1, 64'(d_id_pc[1]), 64'h14);
    tick();
    check("lit_rel_pc18",  1, 64'(d_id_pc[1]), 64'h18);

    // refill then flush with a push offered; fetch redirects afterwards
    stall = 6'b000100;
    tick(); tick();
    check("lit_refill_cnt", 1, 64'(d_cnt[1]), 64'd2);
    flush = 1'b1;
    tick();
    check("lit_flush_pc",    1, 64'(d_id_pc[1]),  64'd0);
    check("lit_flush_valid", 1, 64'(d_id_val[1]), 64'd0);
    check("lit_flush_cnt",   1, 64'(d_cnt[1]),    64'd0);
    for (int k = 0; k < 3; k++) f_pc[k] = 32'h100;
    flush = 1'b0; stall = 6'b0; vld = 1'b0;

    // idle fetch, no stall: bubble on every depth
    tick();
    check("lit_bubble_inst_d1",  0, 64'(d_id_inst[0]), 64'd0);
    check("lit_bubble_valid_d1", 0, 64'(d_id_val[0]),  64'd0);
    check("lit_bubble_inst_d5",  2, 64'(d_id_inst[2]), 64'd0);
    check("lit_bubble_valid_d5", 2, 64'(d_id_val[2]),  64'd0);

    // random traffic; long stall runs let DEPTH=5 fill and wrap repeatedly
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(199) == 0);
      flush = ($urandom_range(59) == 0);
      stall = 6'($urandom);
      stall[2] = ($urandom_range(9) < 5);
      vld   = ($urandom_range(9) < 7);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
